// File: rtl/pipe_alu_pkg.sv
// Shared opcodes, default sizes and pipeline depth for the register-bank ALU pipeline.
package pipe_alu_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_NREGS  = 16;
   localparam int DEF_MDEPTH = 256;

   // vld_pipe[0] is the RD/EX stage, vld_pipe[STAGES] drives out_valid
   localparam int STAGES = 3;
   localparam int VLD_W  = STAGES + 1;
   localparam int FUNC_W = 4;

   typedef logic [FUNC_W-1:0] func_t;

   localparam func_t FN_ADD  = 4'd0;
   localparam func_t FN_SUB  = 4'd1;
   localparam func_t FN_MUL  = 4'd2;
   localparam func_t FN_PASA = 4'd3;
   localparam func_t FN_PASB = 4'd4;
   localparam func_t FN_AND  = 4'd5;
   localparam func_t FN_OR   = 4'd6;
   localparam func_t FN_XOR  = 4'd7;
   localparam func_t FN_NEGA = 4'd8;
   localparam func_t FN_NEGB = 4'd9;
   localparam func_t FN_SHRA = 4'd10;
   localparam func_t FN_SHRB = 4'd11;

endpackage

// File: rtl/pipe_alu_core.sv
// Combinational ALU: z = func(a, b), truncated to WIDTH bits.
module pipe_alu_core
   import pipe_alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [FUNC_W-1:0] func,
   output logic [WIDTH-1:0]  z
);

   always_comb begin
      z = '0;
      case (func)
         FN_ADD:  z = a + b;
         FN_SUB:  z = a - b;
         FN_MUL:  z = a * b;
         FN_PASA: z = a;
         FN_PASB: z = b;
         FN_AND:  z = a & b;
         FN_OR:   z = a | b;
         FN_XOR:  z = a ^ b;
         FN_NEGA: z = -a;
         FN_NEGB: z = -b;
         FN_SHRA: z = a >> 1;
         FN_SHRB: z = b >> 1;
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/pipe_alu_regmem.sv
// 4-stage RD/EX/WB/MS ALU pipeline with register bank, data memory and debug read port.
// Define PIPE_ALU_FWD_EN to bypass EX/WB results into operand read.
module pipe_alu_regmem
   import pipe_alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter int MDEPTH = DEF_MDEPTH,
   localparam int RAW   = $clog2(NREGS),
   localparam int MAW   = $clog2(MDEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [RAW-1:0]    rs1,
   input  logic [RAW-1:0]    rs2,
   input  logic [RAW-1:0]    rd,
   input  logic [3:0]        func,
   input  logic [MAW-1:0]    addr,
   output logic              out_valid,
   output logic [WIDTH-1:0]  zout,
   output logic              out_zero,
   output logic [MAW-1:0]    out_addr,
   input  logic [MAW-1:0]    dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
);

   logic [STAGES:0]   vld_pipe;
   logic [WIDTH-1:0]  regbank [NREGS];
   logic [WIDTH-1:0]  mem [MDEPTH];

   logic [WIDTH-1:0]  opa, opb;
   logic [WIDTH-1:0]  ex_a, ex_b, ex_z;
   logic [3:0]        ex_func;
   logic [RAW-1:0]    ex_rd, wb_rd;
   logic [MAW-1:0]    ex_addr, wb_addr, ms_addr;
   logic [WIDTH-1:0]  wb_z, ms_z;

   pipe_alu_core #(.WIDTH(WIDTH)) u_core (
      .a    (ex_a),
      .b    (ex_b),
      .func (ex_func),
      .z    (ex_z)
   );

   always_comb begin
      opa = regbank[rs1];
      opb = regbank[rs2];
`ifdef PIPE_ALU_FWD_EN
      // youngest producer wins: EX result beats the WB register
      if (vld_pipe[0] && ex_rd == rs1)      opa = ex_z;
      else if (vld_pipe[1] && wb_rd == rs1) opa = wb_z;
      if (vld_pipe[0] && ex_rd == rs2)      opb = ex_z;
      else if (vld_pipe[1] && wb_rd == rs2) opb = wb_z;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_func  <= '0;
         ex_rd    <= '0;
         ex_addr  <= '0;
         wb_z     <= '0;
         wb_rd    <= '0;
         wb_addr  <= '0;
         ms_z     <= '0;
         ms_addr  <= '0;
         zout     <= '0;
         out_zero <= 1'b1;
         out_addr <= '0;
         for (int i = 0; i < NREGS; i++) regbank[i] <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
         ex_a     <= opa;
         ex_b     <= opb;
         ex_func  <= func;
         ex_rd    <= rd;
         ex_addr  <= addr;
         wb_z     <= ex_z;
         wb_rd    <= ex_rd;
         wb_addr  <= ex_addr;
         if (vld_pipe[1]) regbank[wb_rd] <= wb_z;
         ms_z     <= wb_z;
         ms_addr  <= wb_addr;
         // outputs hold the last completed op across bubbles
         if (vld_pipe[2]) begin
            zout     <= ms_z;
            out_zero <= (ms_z == '0);
            out_addr <= ms_addr;
         end
      end
   end

   // memory is not reset; reset clears vld_pipe so no store follows it
   always_ff @(posedge clk) begin
      if (vld_pipe[2]) mem[ms_addr] <= ms_z;
   end

   assign out_valid = vld_pipe[STAGES];
   assign dbg_data  = mem[dbg_addr];

endmodule

// File: tb/tb_pipe_alu_regmem.sv
// Directed bench for pipe_alu_regmem: vector table plus hazard, reset and bubble sequences.
module tb_pipe_alu_regmem;
   import pipe_alu_pkg::*;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
   logic [7:0]  addr = '0, dbg_addr = '0, out_addr;
   logic        out_valid, out_zero;
   logic [W-1:0] zout, dbg_data;

   int checks = 0;
   int errors = 0;

   pipe_alu_regmem dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
      .func(func), .addr(addr), .out_valid(out_valid), .zout(zout), .out_zero(out_zero),
      .out_addr(out_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rs1, rs2, rd, func;
      logic [7:0]  addr;
      logic [15:0] a, b, z;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int k = 0; k < 16; k++) dut.regbank[k] = W'(k);
   endtask

   task automatic drive(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] d, input logic [3:0] f, input logic [7:0] ad);
      in_valid = v; rs1 = a1; rs2 = a2; rd = d; func = f; addr = ad;
   endtask

   task automatic mem_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      chk(name, dbg_data, exp);
   endtask

   task automatic run_dep(input int gap);
      logic [15:0] exp;
      preload();
      drive(1, 3, 5, 10, FN_ADD, 8'd20);
      step();
      for (int g = 0; g < gap; g++) begin
         drive(0, 0, 0, 0, FN_ADD, 8'd0);
         step();
      end
      drive(1, 10, 5, 12, FN_ADD, 8'd21);
      step();
      drive(0, 0, 0, 0, FN_ADD, 8'd0);
      step(); step(); step();
`ifdef PIPE_ALU_FWD_EN
      exp = 16'd13;
`else
      exp = (gap >= 2) ? 16'd13 : 16'd15;
`endif
      chk($sformatf("dep_gap%0d_valid", gap), out_valid, 1);
      chk($sformatf("dep_gap%0d_zout", gap), zout, exp);
      chk($sformatf("dep_gap%0d_addr", gap), out_addr, 8'd21);
   endtask

   logic pat [4];

   initial begin
      vt[0]  = '{4'd3,  4'd5,  4'd10, FN_ADD,  8'd125, 16'd3,      16'd5,   16'd8};
      vt[1]  = '{4'd1,  4'd2,  4'd11, FN_MUL,  8'd30,  16'd300,    16'd300, 16'd24464};
      vt[2]  = '{4'd1,  4'd5,  4'd12, FN_SUB,  8'd31,  16'd1,      16'd5,   16'hFFFC};
      vt[3]  = '{4'd0,  4'd0,  4'd13, FN_NEGA, 8'd32,  16'd0,      16'd0,   16'd0};
      vt[4]  = '{4'd3,  4'd5,  4'd13, 4'd13,   8'd33,  16'd3,      16'd5,   16'd0};
      vt[5]  = '{4'd9,  4'd1,  4'd14, FN_SHRA, 8'd34,  16'd9,      16'd1,   16'd4};
      vt[6]  = '{4'd1,  4'd7,  4'd14, FN_SHRB, 8'd35,  16'd1,      16'd7,   16'd3};
      vt[7]  = '{4'd12, 4'd10, 4'd15, FN_AND,  8'd36,  16'd12,     16'd10,  16'd8};
      vt[8]  = '{4'd12, 4'd10, 4'd15, FN_OR,   8'd37,  16'd12,     16'd10,  16'd14};
      vt[9]  = '{4'd12, 4'd10, 4'd15, FN_XOR,  8'd38,  16'd12,     16'd10,  16'd6};
      vt[10] = '{4'd2,  4'd1,  4'd15, FN_NEGB, 8'd39,  16'd2,      16'd1,   16'hFFFF};
      vt[11] = '{4'd7,  4'd6,  4'd15, FN_PASA, 8'd45,  16'd7,      16'd6,   16'd7};
      vt[12] = '{4'd7,  4'd6,  4'd15, FN_PASB, 8'd46,  16'd7,      16'd6,   16'd6};
      vt[13] = '{4'd1,  4'd2,  4'd9,  FN_ADD,  8'd47,  16'hFFFF,   16'd1,   16'd0};

      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_zout", zout, 0);
      chk("rst_out_zero", out_zero, 1);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_regbank5", dut.regbank[5], 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         preload();
         dut.regbank[vt[i].rs1] = vt[i].a;
         dut.regbank[vt[i].rs2] = vt[i].b;
         drive(1, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].func, vt[i].addr);
         step();
         drive(0, 0, 0, 0, FN_ADD, 8'd0);
         step(); step();
         chk($sformatf("v%0d_early_valid", i), out_valid, 0);
         step();
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_zout", i), zout, vt[i].z);
         chk($sformatf("v%0d_zero", i), out_zero, (vt[i].z == 16'd0));
         chk($sformatf("v%0d_addr", i), out_addr, vt[i].addr);
         chk($sformatf("v%0d_regbank", i), dut.regbank[vt[i].rd], vt[i].z);
         mem_chk($sformatf("v%0d_mem", i), vt[i].addr, vt[i].z);
      end

      for (int g = 0; g < 3; g++) run_dep(g);

      // reset while four ops are in flight
      preload();
      for (int i = 0; i < 4; i++) dut.mem[40 + i] = 16'hAAAA;
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'(i + 1), 4'(i + 1), 4'(i + 8), FN_ADD, 8'(40 + i));
         step();
      end
      drive(0, 0, 0, 0, FN_ADD, 8'd0);
      rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_zout", zout, 0);
      chk("midrst_zero", out_zero, 1);
      step(); step();
      rst = 1'b0;
      step(); step(); step(); step();
      chk("midrst_valid_after", out_valid, 0);
      mem_chk("midrst_mem40", 8'd40, 16'd2);
      for (int i = 1; i < 4; i++) mem_chk($sformatf("midrst_mem%0d", 40 + i), 8'(40 + i), 16'hAAAA);
      for (int k = 0; k < 16; k++) chk($sformatf("midrst_reg%0d", k), dut.regbank[k], 0);

      // alternating valid / bubble
      preload();
      dut.mem[51] = 16'h5555;
      dut.mem[53] = 16'h5555;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         case (j)
            0: drive(1, 2, 3, 14, FN_ADD, 8'd50);
            1: drive(0, 6, 6, 13, FN_ADD, 8'd51);
            2: drive(1, 4, 4, 15, FN_ADD, 8'd52);
            3: drive(0, 7, 7, 13, FN_ADD, 8'd53);
            default: drive(0, 0, 0, 0, FN_ADD, 8'd0);
         endcase
         step();
         if (j >= 3 && j <= 6) begin
            chk($sformatf("bub_valid%0d", j - 3), out_valid, pat[j - 3]);
            if (j == 3) chk("bub_zout0", zout, 16'd5);
            if (j == 5) chk("bub_zout2", zout, 16'd8);
         end
      end
      mem_chk("bub_mem50", 8'd50, 16'd5);
      mem_chk("bub_mem51", 8'd51, 16'h5555);
      mem_chk("bub_mem52", 8'd52, 16'd8);
      mem_chk("bub_mem53", 8'd53, 16'h5555);
      chk("bub_reg13", dut.regbank[13], 16'd13);
      chk("bub_reg14", dut.regbank[14], 16'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
